mem_stream_loader: RTL and testbench

//  Byte-stream loader that fills the 16Kx16 dual-port program/data memory through its port B.
//  - Consumes a framed byte stream (header + payload) from the wireless/serial receiver.
//  - Assembles 16-bit words and issues one single-cycle write per word at auto-incrementing addresses.
//  - Used at boot and for live updates; port A stays with the CPU.

---
 rtl/mem_stream_loader.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stream_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_loader.sv
// ---------------------------------------------------------------------------
// mem_stream_loader
//
// Fills a 16-bit-wide memory through its write port from a framed byte
// stream. Frame layout (big-endian):
//   ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN words sent as HI,LO byte pairs.
// Start address is {ADDR_HI[5:0], ADDR_LO}; LEN is a word count (0..65535).
// Each assembled word is written with a one-cycle mem_we pulse, and the
// address auto-increments (wrapping modulo 2**ADDR_WIDTH).
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   A trailing checksum byte follows the payload. It is compared with the
//   XOR of every byte accepted since start; a mismatch raises error.
//   Without the macro there is no checksum byte and error is tied to 0.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          one-cycle pulse arming the loader (ignored while busy)
//   byte_in        stream byte
//   byte_valid     byte_in valid
//   byte_ready     loader accepts byte_in this cycle (transfer = valid & ready)
//   mem_address    memory write address
//   mem_data       memory write data
//   mem_we         memory write enable, one-cycle pulse per word
//   busy           frame in progress
//   done           frame complete, held until next start
//   error          checksum mismatch, held until next start
//   words_written  words written in current/last frame
// ---------------------------------------------------------------------------
module mem_stream_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_written
);

    typedef enum logic [3:0] {
        IDLE,
        A_HI,
        A_LO,
        L_HI,
        L_LO,
        D_HI,
        D_LO,
        WR,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    // State reached once the payload is exhausted (or empty).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic        transfer;
    logic        enter_done;
    logic [5:0]  addr_hi;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [15:0] remaining;

    assign transfer   = byte_valid & byte_ready;
    assign enter_done = (state_next == DONE) && (state != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = A_HI;
            end
            A_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = A_LO;
            end
            A_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = L_HI;
            end
            L_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = L_LO;
            end
            L_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = ({len_hi, byte_in} == 16'd0) ? END_STATE : D_HI;
                end
            end
            D_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = D_LO;
            end
            D_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = WR;
            end
            WR: begin
                // Address and data are registered, so they are stable for
                // the whole write cycle; no byte is taken while writing.
                mem_we     = 1'b1;
                state_next = (remaining == 16'd1) ? END_STATE : D_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = DONE;
            end
`endif
            DONE: begin
                // start is deliberately not looked at here.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address   <= '0;
            mem_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= 16'd0;
            addr_hi       <= 6'd0;
            len_hi        <= 8'd0;
            data_hi       <= 8'd0;
            remaining     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        words_written <= 16'd0;
                    end
                end
                A_HI: if (transfer) addr_hi <= byte_in[5:0];
                A_LO: if (transfer) mem_address <= ADDR_WIDTH'({addr_hi, byte_in});
                L_HI: if (transfer) len_hi <= byte_in;
                L_LO: if (transfer) remaining <= {len_hi, byte_in};
                D_HI: if (transfer) data_hi <= byte_in;
                D_LO: if (transfer) mem_data <= DATA_WIDTH'({data_hi, byte_in});
                WR: begin
                    mem_address   <= mem_address + 1'b1;
                    words_written <= words_written + 16'd1;
                    remaining     <= remaining - 16'd1;
                end
                default: ;
            endcase
            if (enter_done) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
    logic       error_q;

    assign error = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= 8'd0;
            error_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                checksum <= 8'd0;
                error_q  <= 1'b0;
            end
        end else if (transfer) begin
            // The checksum byte itself is compared, not accumulated.
            if (state == CHK) begin
                if (byte_in != checksum) error_q <= 1'b1;
            end else begin
                checksum <= checksum ^ byte_in;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_stream_loader
//
// Drives framed byte streams into mem_stream_loader and checks every memory
// write against a scoreboard of expected {address, data} pairs built from a
// small reference model of the frame. Honors LOADER_CHECKSUM_EN the same way
// the design does.
// ---------------------------------------------------------------------------
module tb_mem_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [13:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    mem_stream_loader #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {address[13:0], data[15:0]}
    logic [29:0] sb[$];

    // Reference model state
    logic [13:0] m_addr;
    logic [7:0]  m_chk;
    logic [15:0] m_words;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (sb.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                logic [29:0] e;
                e = sb.pop_front();
                check("wr_addr", {18'd0, mem_address}, {18'd0, e[29:16]});
                check("wr_data", {16'd0, mem_data}, {16'd0, e[15:0]});
            end
            check("ready_in_wr", {31'd0, byte_ready}, 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All tasks start and end at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int n;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_chk   = 8'h00;
        m_words = 16'd0;
    endtask

    task automatic send_header(input logic [7:0] ahi, input logic [7:0] alo,
                               input logic [15:0] len, input int maxgap);
        send_byte(ahi, maxgap);
        send_byte(alo, maxgap);
        send_byte(len[15:8], maxgap);
        send_byte(len[7:0], maxgap);
        m_chk  = m_chk ^ ahi ^ alo ^ len[15:8] ^ len[7:0];
        m_addr = {ahi[5:0], alo};
    endtask

    task automatic send_word(input logic [15:0] w, input int maxgap);
        send_byte(w[15:8], maxgap);
        sb.push_back({m_addr, w});
        send_byte(w[7:0], maxgap);
        m_chk   = m_chk ^ w[15:8] ^ w[7:0];
        m_addr  = m_addr + 14'd1;
        m_words = m_words + 16'd1;
    endtask

    task automatic finish_frame(input logic [7:0] cb);
        int n;
        logic exp_err;
`ifdef LOADER_CHECKSUM_EN
        send_byte(cb, 0);
        exp_err = (cb != m_chk);
`else
        exp_err = 1'b0;
`endif
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("words_written", {16'd0, words_written}, {16'd0, m_words});
        check("addr_end", {18'd0, mem_address}, {18'd0, m_addr});
        check("error", {31'd0, error}, {31'd0, exp_err});
        check("sb_empty", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("done_held", {31'd0, done}, 32'd1);
        check("ready_idle", {31'd0, byte_ready}, 32'd0);
    endtask

    task automatic frame1(input int maxgap, input bit good_chk, input logic [7:0] bad_byte);
        do_start();
        send_header(8'h00, 8'h10, 16'd3, maxgap);
        check("busy_frame", {31'd0, busy}, 32'd1);
        send_word(16'hABCD, maxgap);
        send_word(16'h1234, maxgap);
        send_word(16'hFF00, maxgap);
        finish_frame(good_chk ? m_chk : bad_byte);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_rdy"},   {31'd0, byte_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_err"},   {31'd0, error}, 32'd0);
        check({tag, "_addr"},  {18'd0, mem_address}, 32'd0);
        check({tag, "_data"},  {16'd0, mem_data}, 32'd0);
        check({tag, "_words"}, {16'd0, words_written}, 32'd0);
    endtask

    initial begin
        m_addr  = 14'd0;
        m_chk   = 8'h00;
        m_words = 16'd0;

        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // Basic three-word frame, back-to-back bytes
        frame1(0, 1'b1, 8'h00);

        // Address wrap, with a start pulse mid-frame that must be ignored
        do_start();
        send_header(8'h3F, 8'hFF, 16'd2, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        finish_frame(m_chk);

        // Zero-length frame; ADDR_HI[7:6] ignored
        do_start();
        send_header(8'hC0, 8'h05, 16'd0, 0);
        finish_frame(m_chk);

        // Same as the first frame with random valid gaps
        frame1(3, 1'b1, 8'h00);

        // Reset between HI and LO of word 2
        do_start();
        send_header(8'h00, 8'h10, 16'd3, 0);
        send_word(16'hABCD, 0);
        send_byte(8'h12, 0);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst_sb", sb.size(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame1(1, 1'b1, 8'h00);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte, then a correct one
        frame1(0, 1'b0, 8'h00);
        frame1(0, 1'b1, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
